// File: rtl/sar_adc_sampler.sv
// sar_adc_sampler
// Conversion sequencer and oversampling front end for the 8-bit SAR ADC path.
// It issues periodic one-cycle adc_start pulses to sar_adc_controller and
// captures adc_val on each rising edge of out_valid. It averages 2^LOG2_AVG
// results and presents each average on a valid/ready output. Two sticky
// error flags are provided: overrun and timeout_err.
//
// Ports
//   clk           system clock, all logic on posedge
//   rst_n         asynchronous active-low reset
//   enable        schedule conversions while high
//   period        cycles between adc_start pulses (0 behaves as 1)
//   adc_start     one-cycle start pulse to the controller
//   adc_val       controller result
//   out_valid     controller result-valid level
//   sample_data   averaged sample
//   sample_valid  sample_data valid, held until accepted
//   sample_ready  downstream accept
//   overrun       sticky: a finished average was dropped (output occupied)
//   timeout_err   sticky: a conversion did not finish within TIMEOUT cycles
//   clear_err     synchronous clear of both flags (a set in the same cycle wins)
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for enable and for the period timer to expire
// START | adc_start high for this single cycle
// WAIT  | conversion in flight, waiting for an out_valid rising edge

module sar_adc_sampler #(
    parameter int BITS     = 8,
    parameter int LOG2_AVG = 2,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 31
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                adc_start,
    input  logic [BITS-1:0]     adc_val,
    input  logic                out_valid,
    output logic [BITS-1:0]     sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    output logic                timeout_err,
    input  logic                clear_err
);

    localparam int ACC_W = BITS + LOG2_AVG;
    localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PERIOD_W-1:0] timer;
    logic [PERIOD_W-1:0] period_m1;
    logic [TO_W-1:0]     to_cnt;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [CNT_W-1:0]    cnt;
    logic                out_valid_q;
    logic                ov_rise;
    logic                capture;
    logic                to_hit;
    logic                group_done;
    logic                drop_group;
    logic                overrun_set;

    assign period_m1   = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign ov_rise     = out_valid && !out_valid_q;
    assign acc_sum     = acc + ACC_W'(adc_val);
    assign group_done  = capture && (cnt == CNT_LAST);
    // A partial group is abandoned on timeout, and whenever the sequencer is
    // (or is about to be) idle with enable low.
    assign drop_group  = to_hit || (!enable && (state_nxt == ST_IDLE));
    assign overrun_set = group_done && sample_valid && !sample_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        to_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && (timer >= period_m1)) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the last allowed cycle still counts.
                if (ov_rise) begin
                    capture   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (to_cnt == TO_LAST) begin
                    to_hit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The timer is cleared on the edge that enters START, so consecutive
    // starts are exactly max(period,1) cycles apart when the conversion fits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer       <= '0;
            to_cnt      <= '0;
            adc_start   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (state_nxt == ST_START) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + PERIOD_W'(1);
            end
            if (state == ST_WAIT) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end
            adc_start   <= (state_nxt == ST_START);
            out_valid_q <= out_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (group_done || drop_group) begin
            acc <= '0;
            cnt <= '0;
        end else if (capture) begin
            acc <= acc_sum;
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else if (group_done && (!sample_valid || sample_ready)) begin
            sample_data  <= BITS'(acc_sum >> LOG2_AVG);
            sample_valid <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
            if (to_hit) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sar_adc_sampler.md
# sar_adc_sampler

Conversion sequencer and oversampling front end for the 8-bit SAR ADC path. It sits directly downstream of `sar_adc_controller`. It issues periodic single-cycle `adc_start` pulses and captures `adc_val` when the controller's `out_valid` rises. It averages 2^LOG2_AVG consecutive conversions and presents each averaged sample to the edge accelerator datapath over a valid/ready interface, with sticky overrun and timeout flags.

## Interface
- BITS, 8, ADC result width; must match `sar_adc_controller` BITS
- LOG2_AVG, 2, log2 of conversions averaged per output sample (0 = no averaging)
- PERIOD_W, 16, width of the conversion period register
- TIMEOUT, 31, max cycles to wait in WAIT for out_valid before aborting
- clk  input  1  system clock; all logic on posedge
- rst_n  input  1  reset; asynchronous, active-low
- enable  input  1  when high, conversions are scheduled
- period  input  PERIOD_W  cycles between successive adc_start pulses; 0 treated as 1
- adc_start  output  1  one-cycle start pulse to controller
- adc_val  input  BITS  controller result
- out_valid  input  1  controller result-valid level
- sample_data  output  BITS  averaged sample
- sample_valid  output  1  sample_data valid; held until accepted
- sample_ready  input  1  downstream accept
- overrun  output  1  sticky: completed average dropped because output was still occupied
- timeout_err  output  1  sticky: conversion did not complete within TIMEOUT cycles
- clear_err  input  1  synchronous clear of overrun and timeout_err

## Operation
- Reset values: adc_start=0, sample_data=0, sample_valid=0, overrun=0, timeout_err=0. State=IDLE; period timer, timeout counter, accumulator, and sample count are all 0.
- FSM states: IDLE, START, WAIT.
  - IDLE -> START when enable=1 and the period timer ≥ max(period,1)-1.
  - START drives adc_start=1 for exactly one cycle, clears the period timer, then goes to WAIT.
  - WAIT -> IDLE on an out_valid rising edge (out_valid=1 and registered previous out_valid=0), or on timeout.
- The period timer increments every cycle and saturates at all-ones. If the period is shorter than the conversion, the next start occurs on the first IDLE cycle after capture.
- Capture only counts a rising edge in WAIT. A level out_valid left high from a previous conversion is never captured. Rising edges outside WAIT are ignored.
- Accumulator width is BITS+LOG2_AVG and is zero-extended per capture. The sample count runs 0..2^LOG2_AVG-1.
- When the capture completes a group, the result is acc>>LOG2_AVG (truncate, no rounding). The accumulator and count then clear.
- Output register behaviour:
  - If sample_valid=0, or sample_valid=1 and sample_ready=1 in the same cycle, the new result loads and sample_valid=1.
  - Otherwise the new result is discarded, sample_data is unchanged, and overrun is set.
- Handshake: a transfer occurs on a cycle with sample_valid=1 and sample_ready=1. sample_valid falls next cycle unless a new result loads that same cycle.
- Timeout: a counter runs in WAIT. On reaching TIMEOUT, timeout_err is set, the partial group (accumulator and count) is discarded, and the FSM returns to IDLE.
- enable=0: no new START. An in-flight conversion completes and is captured. On entering IDLE with enable=0, the partial group is cleared. The output register is unaffected.
- Flags: clear_err clears both flags. A set in the same cycle as clear_err wins.
- Reset mid-operation: all state is cleared immediately (asynchronously). A conversion in flight at release is never captured.

## Timing
- adc_start is registered and high for exactly 1 cycle per START.
- Capture: a rising edge sampled at posedge N completes the group, and sample_valid=1 from cycle N+1.
- The minimum start-to-start spacing is conversion time + 2 cycles (START, WAIT..capture, IDLE).
- The first adc_start occurs max(period,1) cycles after enable rises from reset (the timer starts at 0).
- Output throughput is 1 sample per 2^LOG2_AVG conversions. No combinational path runs from sample_ready to sample_valid.

## Test plan
Default parameters throughout. The bench uses a behavioral controller model with a 10-cycle conversion, out_valid low on start and high on completion.
- Model returns 0x5A ×4, period=20, sample_ready=1 -> one sample_data=0x5A pulse; adc_start pulses exactly 20 cycles apart.
- Returns 0x01,0x02,0x03,0x03 -> sample_data=0x02 (sum 9>>2). Returns 0xFF ×4 -> 0xFF with no wrap.
- period=2 -> starts back-to-back, one IDLE cycle after each capture; period=0 behaves identically.
- sample_ready=0 across two groups (0x10 then 0x20) -> sample_data stays 0x10 and overrun=1. Then ready=1 accepts 0x10. clear_err -> overrun=0.
- Model never raises out_valid -> timeout_err=1 exactly TIMEOUT cycles after entering WAIT. The next group of 4 × 0x40 yields 0x40 with no partial carry-in.
- rst_n pulsed low mid-WAIT with 2 samples accumulated -> all outputs 0 immediately. After release, the next 4 × 0x08 give 0x08.
